period_meter: RTL
=================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the cycle counter and period output.
REQ-002 SHALL have parameter TIMEOUT, default 32'd16777215, the maximum clk cycles waited for a rising edge.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port sig_in, input, 1, slow signal to measure, asynchronous to clk (e.g. a clkdiv tap).
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a measurement.
REQ-007 SHALL have port cont, input, 1, continuous mode when 1; sampled every cycle in MEAS.
REQ-008 SHALL have port period, output, CNT_W, clk cycles between two consecutive sig_in rising edges.
REQ-009 SHALL have port valid, output, 1, one-cycle pulse marking a new period value.
REQ-010 SHALL have port busy, output, 1, high while in ARM or MEAS.
REQ-011 SHALL have port timeout, output, 1, sticky flag: the last measurement aborted without an edge.

Function
REQ-012 SHALL pass sig_in through a two-flop synchronizer (s1, s2) and a third flop s3.
REQ-013 SHALL define rise = s2 & ~s3, high for exactly one cycle per synchronized rising edge.
REQ-014 SHALL implement the FSM states IDLE, ARM and MEAS.
REQ-015 IDLE: on start=1, SHALL go to ARM, clear cnt to 0 and clear timeout to 0.
REQ-016 IDLE: start=0 SHALL hold the state; sig_in edges SHALL be ignored.
REQ-017 ARM: on rise, SHALL go to MEAS with cnt<=1; otherwise cnt<=cnt+1.
REQ-018 MEAS: without rise, SHALL update cnt<=cnt+1.
REQ-019 MEAS with rise SHALL load period<=cnt and assert valid=1 in the next cycle.
REQ-020 MEAS with rise and cont=0 SHALL then go to IDLE.
REQ-021 MEAS with rise and cont=1 SHALL stay in MEAS with cnt<=1 (that edge starts the next period).
REQ-022 Result rule: a signal with a period of P clk cycles SHALL yield period=P.
REQ-023 Timeout: in ARM or MEAS, when cnt==TIMEOUT and rise=0, SHALL go to IDLE, set timeout=1, leave period unchanged and keep valid=0.
REQ-024 Simultaneous events: cnt==TIMEOUT together with rise SHALL count as an edge (REQ-019..021), not a timeout.
REQ-025 valid SHALL be registered, exactly one cycle wide per measurement, and never asserted outside a MEAS rise.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 start in the same cycle valid=1 SHALL be accepted, because the state is already IDLE.
REQ-028 busy SHALL be a registered decode of the state, high in ARM and MEAS.
REQ-029 cnt SHALL never wrap; TIMEOUT SHALL be less than 2^CNT_W-1.
REQ-030 period SHALL hold its last value until overwritten by the next valid.

Reset
REQ-031 rst=1 at a clk edge SHALL force: state=IDLE, s1=s2=s3=0, cnt=0, period=0, valid=0, busy=0, timeout=0.
REQ-032 rst SHALL have priority over start, rise and timeout in the same cycle.
REQ-033 rst mid-measurement SHALL abort with no valid pulse and no timeout flag.
REQ-034 After rst deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-035 Single shot: sig_in with period 20 clk cycles, start pulse, cont=0 -> exactly one valid pulse with period=20, busy drops in the same cycle valid rises.
REQ-036 Continuous: sig_in period 8, cont=1 -> valid every 8 cycles with period=8 each time; set cont=0 -> after the next valid, busy=0.
REQ-037 Timeout: TIMEOUT=100, sig_in held 0, start -> busy high for 101 cycles, then timeout=1, valid never asserted, period unchanged.
REQ-038 Reset mid-run: start, one sig_in edge, rst pulse before the second edge -> all outputs 0, no valid, state IDLE.
REQ-039 start ignored while busy: a second start during MEAS -> period=P from the first edge pair only; start on the valid cycle -> new measurement begins.
REQ-040 Edge-at-timeout: second edge timed so rise coincides with cnt==TIMEOUT -> valid=1, period=TIMEOUT, timeout=0.

Source files
------------

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period of a slow, clk-asynchronous signal in clk cycles.
// sig_in is synchronized (s1, s2) and delayed once more (s3) so that each
// synchronized rising edge gives a single-cycle 'rise' strobe. A measurement
// waits in ARM for a first edge, then counts in MEAS until the next edge and
// reports the distance between the two as 'period'.
//
// Handshake: 'start' is a one-cycle request, accepted only in IDLE (busy=0);
// requests while busy=1 are dropped. 'valid' is a one-cycle registered pulse
// qualifying a new 'period'. 'period' holds until the next valid. Because the
// single-shot FSM is already back in IDLE on the valid cycle, a start on that
// same cycle is accepted. No back-pressure exists on the result.
//
// Parameters
//   CNT_W    width of the cycle counter and of 'period'
//   TIMEOUT  max clk cycles waited for a rising edge (must be < 2^CNT_W-1)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   sig_in     signal to measure (asynchronous to clk)
//   start      request to begin a measurement
//   cont       1 = continuous mode, re-measure on every edge
//   period     clk cycles between two consecutive rising edges of sig_in
//   valid      one-cycle pulse marking a new period value
//   busy       high while in ARM or MEAS
//   timeout    sticky: last measurement aborted for lack of an edge
//   dbg_state  current FSM state (0=IDLE, 1=ARM, 2=MEAS)
// -----------------------------------------------------------------------------
module period_meter #(
   parameter int          CNT_W   = 32,
   parameter int unsigned TIMEOUT = 32'd16777215
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic             cont,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             busy,
   output logic             timeout,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic             valid_nxt;
   logic             timeout_nxt;
   logic             busy_nxt;
   logic             s1, s2, s3;
   logic             rise;
   logic             at_limit;

   assign rise      = s2 & ~s3;
   assign at_limit  = (cnt == LIMIT);
   assign dbg_state = state;

   // Synchronizer plus edge-detect delay stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         period  <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         period  <= period_nxt;
         valid   <= valid_nxt;
         busy    <= busy_nxt;
         timeout <= timeout_nxt;
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      period_nxt  = period;
      valid_nxt   = 1'b0;
      timeout_nxt = timeout;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = ARM;
               cnt_nxt     = '0;
               timeout_nxt = 1'b0;
            end
         end

         ARM: begin
            // An edge on the limit cycle still counts as an edge.
            if (rise) begin
               state_nxt = MEAS;
               cnt_nxt   = CNT_W'(1);
            end else if (at_limit) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         MEAS: begin
            if (rise) begin
               period_nxt = cnt;
               valid_nxt  = 1'b1;
               // The closing edge also opens the next period in cont mode.
               cnt_nxt    = CNT_W'(1);
               if (!cont) begin
                  state_nxt = IDLE;
               end
            end else if (at_limit) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // busy is decoded from the next state so it falls on the same edge that
   // raises valid at the end of a single-shot measurement.
   assign busy_nxt = (state_nxt == ARM) || (state_nxt == MEAS);

endmodule
